unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
Arbitrates a single-ported unified instruction/data memory between two pipeline requesters:
- the IF stage (instruction fetch);
- the MEM stage (load/store).

It serialises accesses, sequences the fixed-latency memory, and returns per-port ready pulses and stall signals for the hazard logic. Data accesses have priority. A streak limit prevents fetch starvation.

Parameters:
AW, 32, address width (byte address, passed through unchanged)
DW, 32, data width
MEM_LAT, 2, memory read latency in cycles after m_en cycle (>=1)
MAX_DSTREAK, 4, max consecutive data grants while i_req is pending (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
i_req  input  1  fetch request; held with stable i_addr until i_ready
i_addr  input  AW  fetch address
i_ready  output  1  one-cycle pulse: fetch complete, i_rdata valid
i_rdata  output  DW  fetched instruction; held until next fetch completion
d_req  input  1  data request; held with stable d_* inputs until d_ready
d_we  input  1  1 = store, 0 = load
d_addr  input  AW  data address
d_wdata  input  DW  store data
d_ready  output  1  one-cycle pulse: data access complete (load data valid)
d_rdata  output  DW  load data; held until next data completion
stall_if  output  1  i_req & ~i_ready (combinational)
stall_mem  output  1  d_req & ~d_ready (combinational)
m_en  output  1  memory access strobe, exactly one cycle per transaction
m_we  output  1  memory write enable, valid with m_en
m_addr  output  AW  memory address, registered
m_wdata  output  DW  memory write data, registered
m_rdata  input  DW  memory read data, valid MEM_LAT cycles after the m_en cycle

Behaviour:
- Reset values (async on rst=1): state IDLE; all outputs 0, including i_rdata, d_rdata, m_addr, m_wdata; streak counter 0; owner 0.
- FSM: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE -> IDLE. There is one outstanding transaction, with no pipelining.
- IDLE, if any request is pending:
  - choose a winner;
  - latch owner, we, addr and wdata;
  - go to ISSUE.
- IDLE with no request: stay in IDLE.
- Arbitration in IDLE:
  - d_req only -> data;
  - i_req only -> fetch;
  - both pending -> data, unless streak == MAX_DSTREAK, in which case fetch wins.
- Streak counter:
  - increments on each data grant made while i_req=1;
  - clears on every fetch grant;
  - is unchanged on a data grant made while i_req=0;
  - saturates at MAX_DSTREAK;
  - width is clog2(MAX_DSTREAK+1).
- ISSUE (1 cycle): m_en=1; m_we = latched we, forced 0 for fetch; m_addr/m_wdata driven from the latches. m_en=0 and m_we=0 in every other state.
- WAIT: counts MEM_LAT cycles. On the last WAIT cycle, m_rdata is captured into i_rdata or d_rdata according to owner. Stores do not update d_rdata.
- DONE (1 cycle): i_ready or d_ready =1 according to owner; then IDLE. The still-high req in DONE is not sampled.
- Latency: request first seen in IDLE at cycle 0 -> ready at cycle MEM_LAT+2. Back-to-back same-port service rate is one transaction per MEM_LAT+3 cycles.
- Inputs are sampled only in IDLE. Changes to addr/we/wdata mid-transaction are ignored. If req drops mid-transaction, the transaction still completes and ready still pulses.
- i_ready and d_ready are never high in the same cycle. Ready pulses only in DONE.
- Reset mid-transaction aborts immediately to IDLE with no ready pulse. A store already issued (past ISSUE) is not undone.

Test Plan:
- MEM_LAT=2, i_req=1, i_addr=0x10 at cycle 0, memory model returns 0x8C220004 -> m_en cycle 1 with m_addr=0x10, m_we=0; i_ready pulse at cycle 4; i_rdata=0x8C220004; stall_if=1 for cycles 0-3.
- Store then load: d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF -> m_we=1 with m_en, d_ready at cycle 4, d_rdata unchanged. Then a load of 0x20 -> d_rdata=0xDEADBEEF.
- Simultaneous i_req and d_req at cycle 0, streak=0 -> data granted first (d_ready cycle 4). Fetch issues next: m_en at cycle 6, i_ready at cycle 9.
- Starvation guard: MAX_DSTREAK=4, i_req held, d_req re-raised immediately after each d_ready -> four data grants, then the 5th grant goes to fetch; streak returns to 0.
- MEM_LAT=1 -> ready at cycle 3. MEM_LAT=4 -> ready at cycle 6. m_en is high for exactly one cycle per transaction.
- rst pulsed during WAIT of a load -> outputs 0 and state IDLE asynchronously, with no d_ready. After release, the held d_req is re-served from IDLE with normal latency.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Arbiter for a single-ported unified instruction/data memory shared by the IF and MEM stages.
// One transaction in flight: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE -> IDLE.
module unified_mem_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MEM_LAT     = 2,
    parameter int MAX_DSTREAK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ready,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic [DW-1:0] d_rdata,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t          r_state;
    logic            r_owner_d;
    logic            r_we;
    logic [SW-1:0]   r_streak;
    logic [CW-1:0]   r_wait;
    logic            r_i_ready;
    logic            r_d_ready;
    logic            r_m_en;
    logic            r_m_we;
    logic [AW-1:0]   r_m_addr;
    logic [DW-1:0]   r_m_wdata;
    logic [DW-1:0]   r_i_rdata;
    logic [DW-1:0]   r_d_rdata;

    logic            w_any_req;
    logic            w_fetch_turn;
    logic            w_data_win;

    // Data normally wins; a fetch that has waited out MAX_DSTREAK data grants goes first.
    assign w_any_req    = i_req | d_req;
    assign w_fetch_turn = i_req & (r_streak == SW'(MAX_DSTREAK));
    assign w_data_win   = d_req & ~w_fetch_turn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_owner_d <= 1'b0;
            r_we      <= 1'b0;
            r_streak  <= '0;
            r_wait    <= '0;
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            r_m_en    <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            // NOTE: strobes default low every cycle, so each is a one-cycle pulse raised only by its owning state.
            r_m_en    <= 1'b0;
            r_m_we    <= 1'b0;
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner_d <= w_data_win;
                        r_we      <= w_data_win & d_we;
                        r_m_addr  <= w_data_win ? d_addr : i_addr;
                        if (w_data_win) begin
                            r_m_wdata <= d_wdata;
                        end
                        r_m_en    <= 1'b1;
                        r_m_we    <= w_data_win & d_we;
                        if (!w_data_win) begin
                            r_streak <= '0;
                        end else if (i_req && (r_streak != SW'(MAX_DSTREAK))) begin
                            r_streak <= r_streak + 1'b1;
                        end
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wait  <= CW'(MEM_LAT - 1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait == '0) begin
                        // Read data is valid on the last wait cycle; stores leave d_rdata alone.
                        if (!r_owner_d) begin
                            r_i_rdata <= m_rdata;
                        end else if (!r_we) begin
                            r_d_rdata <= m_rdata;
                        end
                        r_i_ready <= ~r_owner_d;
                        r_d_ready <= r_owner_d;
                        r_state   <= S_DONE;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign i_ready   = r_i_ready;
    assign d_ready   = r_d_ready;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign m_en      = r_m_en;
    assign m_we      = r_m_we;
    assign m_addr    = r_m_addr;
    assign m_wdata   = r_m_wdata;
    assign stall_if  = i_req & ~r_i_ready;
    assign stall_mem = d_req & ~r_d_ready;

endmodule
